matrix_mem_ctrl: RTL

MATRIX_MEM_CTRL -- requirements
Module: matrix_mem_ctrl

---
 rtl/matriz_pkg.sv | 69 ++++++
 rtl/elem_seq.sv | 45 ++++
 rtl/matrix_mem_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/matriz_pkg.sv
// Shared constants, state encoding and element helpers for the matrix memory controller.
package matriz_pkg;

    localparam int MAT_W    = 200;
    localparam int ELEM_CNT = 25;
    localparam int ELEM_W   = 8;

    localparam logic [4:0] LAST_IDX = 5'(ELEM_CNT - 1);

    localparam logic [3:0] SOMA          = 4'b0011;
    localparam logic [3:0] SUBTRACAO     = 4'b0100;
    localparam logic [3:0] MULTIPLICACAO = 4'b0101;
    localparam logic [3:0] MULT_ESCALAR  = 4'b0110;
    localparam logic [3:0] TRANSPOSTA    = 4'b0111;
    localparam logic [3:0] OPOSTA        = 4'b1000;
    localparam logic [3:0] DET2          = 4'b1001;
    localparam logic [3:0] DET3          = 4'b1010;
    localparam logic [3:0] DET4          = 4'b1011;
    localparam logic [3:0] DET5          = 4'b1100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_EXEC,
        ST_RELEASE,
        ST_STORE,
        ST_FINISH
    } state_t;

    // Opcodes the ALU understands; anything else is rejected in IDLE.
    function automatic logic op_valid(input logic [3:0] op);
        return (op >= SOMA) && (op <= DET5);
    endfunction

    // Only the two-operand matrix operations need B fetched from memory.
    function automatic logic op_needs_b(input logic [3:0] op);
        return (op == SOMA) || (op == SUBTRACAO) || (op == MULTIPLICACAO);
    endfunction

    // Determinants produce a single byte in result bits [7:0].
    function automatic logic op_scalar_result(input logic [3:0] op);
        return (op >= DET2) && (op <= DET5);
    endfunction

    // Read element idx (row*5+col) out of a packed matrix.
    function automatic logic [ELEM_W-1:0] elem_at(input logic [MAT_W-1:0] m,
                                                  input logic [4:0] idx);
        logic [ELEM_W-1:0] v;
        v = '0;
        for (int k = 0; k < ELEM_CNT; k++) begin
            if (idx == 5'(k)) v = m[k*ELEM_W +: ELEM_W];
        end
        return v;
    endfunction

    // Return m with element idx replaced by v.
    function automatic logic [MAT_W-1:0] set_elem(input logic [MAT_W-1:0] m,
                                                  input logic [4:0] idx,
                                                  input logic [ELEM_W-1:0] v);
        logic [MAT_W-1:0] r;
        r = m;
        for (int k = 0; k < ELEM_CNT; k++) begin
            if (idx == 5'(k)) r[k*ELEM_W +: ELEM_W] = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/elem_seq.sv
// Element sequencer: walks element indices 0..24 for the LOAD and STORE phases.
// nxt_off is the address offset of the element after the current one, so the
// controller can register the next memory address one cycle ahead.
module elem_seq
    import matriz_pkg::*;
#(
    parameter int AW = 8
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          en,
    output logic [4:0]    idx,
    output logic          tc,
    output logic [AW-1:0] nxt_off
);

    logic [4:0] cnt_q;
    logic [4:0] cnt_d;

    // Next count: start wins over advance, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = 5'd0;
        end else if (en) begin
            cnt_d = cnt_q + 5'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 5'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign idx     = cnt_q;
    assign tc      = (cnt_q == LAST_IDX);
    assign nxt_off = AW'(cnt_q) + AW'(1);

endmodule

// File: rtl/matrix_mem_ctrl.sv
// Matrix memory controller: fetches A (and B) 5x5 byte matrices from a byte
// memory, hands them to an external ALU, and writes the result back.
// Handshakes: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high; instr_ready is high only in IDLE. mem_rd_data is
// taken the cycle after mem_rd_en. alu_start is a level held until alu_done.
// All outputs are registered; the FSM, datapath and outputs share one always_ff.
module matrix_mem_ctrl
    import matriz_pkg::*;
#(
    parameter int MEM_AW = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_opcode,
    input  logic [MEM_AW-1:0] instr_addr_a,
    input  logic [MEM_AW-1:0] instr_addr_b,
    input  logic [MEM_AW-1:0] instr_addr_r,
    input  logic [7:0]        instr_scalar,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    output logic [3:0]        alu_opcode,
    output logic [7:0]        alu_scalar,
    output logic [199:0]      alu_matriz_a,
    output logic [199:0]      alu_matriz_b,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [199:0]      alu_result,
    output logic              instr_done,
    output logic              instr_err
);

    state_t              state_q,   state_d;
    logic                ready_q,   ready_d;
    logic                rd_en_q,   rd_en_d;
    logic                wr_en_q,   wr_en_d;
    logic [MEM_AW-1:0]   addr_q,    addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                start_q,   start_d;
    logic                done_q,    done_d;
    logic                err_q,     err_d;
    logic [3:0]          opcode_q,  opcode_d;
    logic [7:0]          scalar_q,  scalar_d;
    logic [MEM_AW-1:0]   addr_a_q,  addr_a_d;
    logic [MEM_AW-1:0]   addr_b_q,  addr_b_d;
    logic [MEM_AW-1:0]   addr_r_q,  addr_r_d;
    logic [MAT_W-1:0]    mat_a_q,   mat_a_d;
    logic [MAT_W-1:0]    mat_b_q,   mat_b_d;
    logic [MAT_W-1:0]    res_q,     res_d;
    logic                cap_en_q,  cap_en_d;
    logic [4:0]          cap_idx_q, cap_idx_d;

    logic                seq_start;
    logic                seq_en;
    logic [4:0]          seq_idx;
    logic                seq_tc;
    logic [MEM_AW-1:0]   seq_off;
    logic [MEM_AW-1:0]   load_base;

    elem_seq #(.AW(MEM_AW)) u_seq (
        .clk     (clk),
        .rst     (rst),
        .start   (seq_start),
        .en      (seq_en),
        .idx     (seq_idx),
        .tc      (seq_tc),
        .nxt_off (seq_off)
    );

    assign load_base = (state_q == ST_LOAD_B) ? addr_b_q : addr_a_q;

    // Next-state, next-output and datapath computation for every register.
    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        start_d   = start_q;
        done_d    = 1'b0;
        err_d     = err_q;
        opcode_d  = opcode_q;
        scalar_d  = scalar_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        addr_r_d  = addr_r_q;
        mat_a_d   = mat_a_q;
        mat_b_d   = mat_b_q;
        res_d     = res_q;
        cap_en_d  = 1'b0;
        cap_idx_d = cap_idx_q;
        seq_start = 1'b0;
        seq_en    = 1'b0;

        // A read issued last cycle returns now; drop it into its slot.
        if (cap_en_q) begin
            if (state_q == ST_LOAD_B) begin
                mat_b_d = set_elem(mat_b_q, cap_idx_q, mem_rd_data);
            end else begin
                mat_a_d = set_elem(mat_a_q, cap_idx_q, mem_rd_data);
            end
        end

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                err_d   = 1'b0;
                if (instr_valid) begin
                    ready_d  = 1'b0;
                    opcode_d = instr_opcode;
                    scalar_d = instr_scalar;
                    addr_a_d = instr_addr_a;
                    addr_b_d = instr_addr_b;
                    addr_r_d = instr_addr_r;
                    if (op_valid(instr_opcode)) begin
                        state_d   = ST_LOAD_A;
                        rd_en_d   = 1'b1;
                        addr_d    = instr_addr_a;
                        seq_start = 1'b1;
                    end else begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end

            ST_LOAD_A, ST_LOAD_B: begin
                if (rd_en_q) begin
                    cap_en_d  = 1'b1;
                    cap_idx_d = seq_idx;
                    if (!seq_tc) begin
                        rd_en_d = 1'b1;
                        addr_d  = load_base + seq_off;
                        seq_en  = 1'b1;
                    end
                end
                // Leave once the 25th byte has been captured.
                if (cap_en_q && (cap_idx_q == LAST_IDX)) begin
                    if ((state_q == ST_LOAD_A) && op_needs_b(opcode_q)) begin
                        state_d   = ST_LOAD_B;
                        rd_en_d   = 1'b1;
                        addr_d    = addr_b_q;
                        seq_start = 1'b1;
                    end else begin
                        state_d = ST_EXEC;
                        start_d = 1'b1;
                    end
                end
            end

            ST_EXEC: begin
                start_d = 1'b1;
                if (alu_done) begin
                    res_d   = alu_result;
                    start_d = 1'b0;
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                state_d   = ST_STORE;
                wr_en_d   = 1'b1;
                addr_d    = addr_r_q;
                wr_data_d = res_q[ELEM_W-1:0];
                seq_start = 1'b1;
            end

            ST_STORE: begin
                if (op_scalar_result(opcode_q) || seq_tc) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                end else begin
                    wr_en_d   = 1'b1;
                    addr_d    = addr_r_q + seq_off;
                    wr_data_d = elem_at(res_q, seq_idx + 5'd1);
                    seq_en    = 1'b1;
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                err_d   = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // FSM state, registered outputs and latched instruction fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b1;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            opcode_q  <= '0;
            scalar_q  <= '0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            addr_r_q  <= '0;
            mat_a_q   <= '0;
            mat_b_q   <= '0;
            res_q     <= '0;
            cap_en_q  <= 1'b0;
            cap_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            start_q   <= start_d;
            done_q    <= done_d;
            err_q     <= err_d;
            opcode_q  <= opcode_d;
            scalar_q  <= scalar_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            addr_r_q  <= addr_r_d;
            mat_a_q   <= mat_a_d;
            mat_b_q   <= mat_b_d;
            res_q     <= res_d;
            cap_en_q  <= cap_en_d;
            cap_idx_q <= cap_idx_d;
        end
    end

    assign instr_ready  = ready_q;
    assign mem_rd_en    = rd_en_q;
    assign mem_wr_en    = wr_en_q;
    assign mem_addr     = addr_q;
    assign mem_wr_data  = wr_data_q;
    assign alu_opcode   = opcode_q;
    assign alu_scalar   = scalar_q;
    assign alu_matriz_a = mat_a_q;
    assign alu_matriz_b = mat_b_q;
    assign alu_start    = start_q;
    assign instr_done   = done_q;
    assign instr_err    = err_q;

endmodule
